// File: rtl/bitserial_mac_seq.sv
// Sequencer for a row of bit-serial multiplier PEs: fetches operand pairs, walks bit_idx MSB-first, handshakes the job result.
// Optional BITSERIAL_PREFETCH_EN: accepts the next pair on the last shift cycle so back-to-back pairs take WIDTH cycles each.
module bitserial_mac_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pe_clr,
  output logic             pe_en,
  output logic [DEPTH-1:0] bit_idx,
  output logic             msb_cyc,
  output logic             pe_acc,
  output logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | waiting for an operand pair
  // SHIFT | PE shift-add, bit_idx WIDTH-1 down to 0
  // OUT   | result held until drain accepts
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, OUT} state_t;

  localparam logic [DEPTH-1:0] IDX_MAX = DEPTH'(WIDTH - 1);

  state_t           state;
  logic [LEN_W-1:0] pairs_left;
  logic             first_pair;
  logic             last_bit;
  logic             prefetch_ok;
  logic             xfer;

  assign last_bit = (state == SHIFT) && (bit_idx == '0);

`ifdef BITSERIAL_PREFETCH_EN
  assign prefetch_ok = last_bit && (pairs_left > LEN_W'(1));
`else
  assign prefetch_ok = 1'b0;
`endif

  assign in_ready  = (state == LOAD) || prefetch_ok;
  assign xfer      = in_valid && in_ready;
  assign pe_clr    = xfer;
  // Only a LOAD transfer can be the first pair; prefetch never is.
  assign acc_clr   = xfer && first_pair;
  assign pe_en     = (state == SHIFT);
  assign pe_acc    = last_bit;
  assign msb_cyc   = pe_en && (bit_idx == IDX_MAX);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_idx    <= IDX_MAX;
      pairs_left <= '0;
      first_pair <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state      <= IDLE;
        bit_idx    <= IDX_MAX;
        pairs_left <= '0;
        first_pair <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_len != '0) begin
                state      <= LOAD;
                pairs_left <= cfg_len;
                first_pair <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (in_valid) begin
              state      <= SHIFT;
              bit_idx    <= IDX_MAX;
              first_pair <= 1'b0;
            end
          end
          SHIFT: begin
            if (bit_idx == '0) begin
              // Reload here so bit_idx never wraps and sits at MSB while stalled in LOAD.
              bit_idx    <= IDX_MAX;
              pairs_left <= pairs_left - LEN_W'(1);
              if (pairs_left == LEN_W'(1)) begin
                state <= OUT;
              end else if (xfer) begin
                state <= SHIFT;
              end else begin
                state <= LOAD;
              end
            end else begin
              bit_idx <= bit_idx - DEPTH'(1);
            end
          end
          OUT: begin
            if (out_ready) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitserial_mac_seq.sv
// Directed bench for bitserial_mac_seq; cycle k is the cycle after the k-th edge following start.
// Expectations switch on BITSERIAL_PREFETCH_EN where the throughput differs.
module tb_bitserial_mac_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_len = '0;
  logic       busy;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       pe_clr;
  logic       pe_en;
  logic [2:0] bit_idx;
  logic       msb_cyc;
  logic       pe_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       done;

  bitserial_mac_seq #(.WIDTH(8), .DEPTH(3), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .cfg_len(cfg_len),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .pe_clr(pe_clr),
    .pe_en(pe_en), .bit_idx(bit_idx), .msb_cyc(msb_cyc), .pe_acc(pe_acc),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int clr_cyc[$];
  int n_en, n_coinc, n_accclr, n_ov, first_ov, done_cyc, n_done, n_busy, n_ir;
  int stall_bad, msb_bad;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clr_at(input int i);
    return (i < clr_cyc.size()) ? clr_cyc[i] : -1;
  endfunction

  // Start a job at edge 0 and observe ncyc cycles; stall/backpressure/restart are cycle-indexed.
  task automatic run_job(input int len, input int stall_lo, input int stall_hi,
                         input int ord_hold, input int restart, input int ncyc);
    int ov_seen;
    clr_cyc.delete();
    n_en = 0; n_coinc = 0; n_accclr = 0; n_ov = 0; first_ov = -1;
    done_cyc = -1; n_done = 0; n_busy = 0; n_ir = 0; stall_bad = 0; msb_bad = 0;
    ov_seen = 0;
    @(negedge clk);
    start = 1'b1; cfg_len = 8'(len); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start   = (c == restart);
      cfg_len = (c == restart) ? 8'd5 : 8'(len);
      in_valid = !(c >= stall_lo && c <= stall_hi);
      #1;
      if (out_valid) begin
        out_ready = (ov_seen >= ord_hold);
        ov_seen++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (pe_clr) clr_cyc.push_back(c);
      if (pe_en) n_en++;
      if (pe_clr && pe_acc) n_coinc++;
      if (acc_clr) n_accclr++;
      if (out_valid) begin
        n_ov++;
        if (first_ov < 0) first_ov = c;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) n_busy++;
      if (in_ready) n_ir++;
      if (c > stall_lo && c <= stall_hi && (pe_en || bit_idx != 3'd7)) stall_bad++;
      if (msb_cyc != (pe_en && bit_idx == 3'd7)) msb_bad++;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int n_late_done;

    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_bit_idx", bit_idx, 7);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // three pairs, continuous input
    run_job(3, 0, 0, 0, 0, 40);
    chk("t1_n_pe_clr", clr_cyc.size(), 3);
    chk("t1_clr0", clr_at(0), 1);
`ifdef BITSERIAL_PREFETCH_EN
    chk("t1_clr1", clr_at(1), 9);
    chk("t1_clr2", clr_at(2), 17);
    chk("t1_first_ov", first_ov, 26);
    chk("t1_done_cyc", done_cyc, 27);
    chk("t1_acc_coincide", n_coinc, 2);
`else
    chk("t1_clr1", clr_at(1), 10);
    chk("t1_clr2", clr_at(2), 19);
    chk("t1_first_ov", first_ov, 28);
    chk("t1_done_cyc", done_cyc, 29);
    chk("t1_acc_coincide", n_coinc, 0);
`endif
    chk("t1_pe_en", n_en, 24);
    chk("t1_acc_clr", n_accclr, 1);
    chk("t1_n_done", n_done, 1);
    chk("t1_msb", msb_bad, 0);

    // two pairs, input stalled 9..14 (LOAD waits 10..14 in both builds)
    run_job(2, 9, 14, 0, 0, 35);
    chk("t3_clr1", clr_at(1), 15);
    chk("t3_stall", stall_bad, 0);
    chk("t3_pe_en", n_en, 16);
    chk("t3_first_ov", first_ov, 24);
    chk("t3_done_cyc", done_cyc, 25);

    // clr during SHIFT with bit_idx=3
    @(negedge clk);
    start = 1'b1; cfg_len = 8'd4; in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 6) begin
        #1;
        chk("t4_pre_idx", bit_idx, 3);
        clr = 1'b1;
        start = 1'b1;
      end
    end
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_pe_en", pe_en, 0);
    chk("t4_bit_idx", bit_idx, 7);
    n_late_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) n_late_done++;
    end
    chk("t4_no_done", n_late_done, 0);
    run_job(1, 0, 0, 0, 0, 15);
    chk("t4_rerun_clr", clr_cyc.size(), 1);
    chk("t4_rerun_ov", first_ov, 10);
    chk("t4_rerun_done", done_cyc, 11);

    // zero-length job
    run_job(0, 0, 0, 0, 0, 5);
    chk("t5_busy", n_busy, 0);
    chk("t5_done_cyc", done_cyc, 1);
    chk("t5_n_done", n_done, 1);
    chk("t5_in_ready", n_ir, 0);

    // start while busy is ignored
    run_job(2, 0, 0, 0, 3, 30);
    chk("t5b_n_clr", clr_cyc.size(), 2);
    chk("t5b_n_done", n_done, 1);
`ifdef BITSERIAL_PREFETCH_EN
    chk("t5b_done_cyc", done_cyc, 19);
`else
    chk("t5b_done_cyc", done_cyc, 20);
`endif

    // backpressure in OUT
    run_job(1, 0, 0, 5, 0, 25);
    chk("t6_first_ov", first_ov, 10);
    chk("t6_n_ov", n_ov, 6);
    chk("t6_done_cyc", done_cyc, 16);
    chk("t6_n_done", n_done, 1);
    chk("t6_msb", msb_bad, 0);

    // asynchronous reset mid-job
    @(negedge clk);
    start = 1'b1; cfg_len = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pe_en", pe_en, 0);
    chk("rst_mid_idx", bit_idx, 7);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
